// File: rtl/dmem_pkg.sv
// dmem_pkg - shared definitions for the byte-lane data memory.
//   size_e    : access size codes (byte / half / word / illegal)
//   state_e   : clear-sequencer states
//   misaligned: 1 when an access of the given size at the given byte offset
//               would cross its natural boundary, or the size code is illegal
//   lane_mask : byte-lane enables touched by an access (lane 0 = bits [7:0])
package dmem_pkg;

   typedef enum logic [1:0] {
      SZ_B   = 2'b00,
      SZ_H   = 2'b01,
      SZ_W   = 2'b10,
      SZ_ILL = 2'b11
   } size_e;

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_READY = 1'b1
   } state_e;

   function automatic logic misaligned(input size_e size, input logic [1:0] off);
      case (size)
         SZ_B:    return 1'b0;
         SZ_H:    return off[0];
         SZ_W:    return (off != 2'b00);
         default: return 1'b1;
      endcase
   endfunction

   function automatic logic [3:0] lane_mask(input size_e size, input logic [1:0] off);
      case (size)
         SZ_B:    return 4'b0001 << off;
         SZ_H:    return off[1] ? 4'b1100 : 4'b0011;
         SZ_W:    return 4'b1111;
         default: return 4'b0000;
      endcase
   endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// dmem_lane_align - combinational lane steering for one 32-bit memory word.
//   size_i     : access size code
//   off_i      : byte offset within the word (address bits [1:0])
//   uns_i      : 1 zero-extends sub-word loads, 0 sign-extends
//   wdata_i    : right-justified store data
//   rword_i    : current contents of the addressed word
//   be_o       : per-lane write enables (all zero when misaligned/illegal)
//   wdata_o    : store data replicated so each enabled lane sees its bytes
//   rdata_o    : selected and extended load data (zero when misaligned/illegal)
//   misalign_o : access is misaligned or has an illegal size
module dmem_lane_align
   import dmem_pkg::*;
(
   input  size_e       size_i,
   input  logic [1:0]  off_i,
   input  logic        uns_i,
   input  logic [31:0] wdata_i,
   input  logic [31:0] rword_i,
   output logic [3:0]  be_o,
   output logic [31:0] wdata_o,
   output logic [31:0] rdata_o,
   output logic        misalign_o
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   assign byte_sel = rword_i[{off_i, 3'b000} +: 8];
   assign half_sel = off_i[1] ? rword_i[31:16] : rword_i[15:0];

   // NOTE: every output is given a default first so no path through the
   // case statements leaves a value unassigned (which would infer a latch).
   always_comb begin
      misalign_o = misaligned(size_i, off_i);
      be_o       = 4'b0000;
      wdata_o    = wdata_i;
      rdata_o    = 32'h0;
      if (!misalign_o) begin
         be_o = lane_mask(size_i, off_i);
         // Replicating the data lets the byte enables pick the right lane
         // without a barrel shifter.
         case (size_i)
            SZ_B: begin
               wdata_o = {4{wdata_i[7:0]}};
               rdata_o = {{24{~uns_i & byte_sel[7]}}, byte_sel};
            end
            SZ_H: begin
               wdata_o = {2{wdata_i[15:0]}};
               rdata_o = {{16{~uns_i & half_sel[15]}}, half_sel};
            end
            SZ_W: begin
               wdata_o = wdata_i;
               rdata_o = rword_i;
            end
            default: begin
               wdata_o = wdata_i;
               rdata_o = 32'h0;
            end
         endcase
      end
   end

endmodule

// File: rtl/dmem_bytelane.sv
// dmem_bytelane - byte/half/word data memory with optional registered read
// port and a post-reset clear sequencer.
//   clk, reset   : single clock; synchronous active-high reset
//   req_valid    : request present;  req_ready: accepted when both high
//   req_we       : 1 store, 0 load
//   req_size     : 00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned : zero-extend sub-word loads when 1
//   req_addr     : byte address (bits above ADDR_W-1 ignored, so it wraps)
//   req_wdata    : right-justified store data
//   rsp_valid    : load data valid;  rsp_rdata: extended load data
//   misalign     : accepted request was misaligned/illegal (rsp timing)
//   busy         : clear sequence running; requests are ignored
module dmem_bytelane
   import dmem_pkg::*;
#(
   parameter int ADDR_W         = 10,
   parameter int READ_LATENCY   = 0,
   parameter int CLEAR_ON_RESET = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   input  logic        req_we,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        req_ready,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        misalign,
   output logic        busy
);

   localparam int IDX_W = ADDR_W - 2;
   localparam int DEPTH = 2 ** IDX_W;

   state_e             state_q, state_d;
   logic [IDX_W-1:0]   cnt_q, cnt_d;

   logic               acc, ld_acc;
   logic [IDX_W-1:0]   idx;
   logic [31:0]        rword;
   logic [3:0]         be;
   logic [31:0]        wdata_sh;
   logic [31:0]        rdata_ext;
   logic               mis;

   logic [3:0]         wr_be;
   logic [IDX_W-1:0]   wr_idx;
   logic [31:0]        wr_data;

   logic               unused_addr;
   assign unused_addr = ^req_addr[31:ADDR_W];

   assign busy      = (state_q == ST_CLEAR);
   assign req_ready = ~busy;
   // Requests seen while reset is high are not accepted even when no clear
   // sequence is configured, so reset leaves both memory and outputs alone.
   assign acc       = req_valid & req_ready & ~reset;
   assign ld_acc    = acc & ~req_we;
   assign idx       = req_addr[ADDR_W-1:2];

   // ---------------- clear sequencer ----------------
   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values of the others, independent of process order.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (state_q == ST_CLEAR) begin
         if (&cnt_q) begin
            state_d = ST_READY;
            cnt_d   = '0;
         end else begin
            cnt_d = cnt_q + IDX_W'(1);
         end
      end
   end

   // ---------------- lane steering ----------------
   dmem_lane_align u_align (
      .size_i     (size_e'(req_size)),
      .off_i      (req_addr[1:0]),
      .uns_i      (req_unsigned),
      .wdata_i    (req_wdata),
      .rword_i    (rword),
      .be_o       (be),
      .wdata_o    (wdata_sh),
      .rdata_o    (rdata_ext),
      .misalign_o (mis)
   );

   // The clear sequencer owns the write port while busy.
   always_comb begin
      wr_be   = 4'b0000;
      wr_idx  = idx;
      wr_data = wdata_sh;
      if (busy) begin
         wr_be   = 4'b1111;
         wr_idx  = cnt_q;
         wr_data = 32'h0;
      end else if (acc && req_we) begin
         wr_be   = be;
      end
   end

   // ---------------- storage: one array per byte lane ----------------
   for (genvar l = 0; l < 4; l++) begin : g_lane
      logic [7:0] lane_mem [DEPTH];

      // NOTE: the array has no reset branch; clearing is done word by word by
      // the sequencer so the storage maps onto plain RAM.
      always_ff @(posedge clk) begin
         if (wr_be[l]) lane_mem[wr_idx] <= wr_data[8*l +: 8];
      end

      assign rword[8*l +: 8] = lane_mem[idx];
   end

   // ---------------- response path ----------------
   if (READ_LATENCY == 0) begin : g_rsp_comb
      assign rsp_valid = ld_acc;
      assign rsp_rdata = ld_acc ? rdata_ext : 32'h0;
      assign misalign  = acc & mis;
   end else begin : g_rsp_reg
      logic        rsp_valid_q;
      logic [31:0] rsp_rdata_q;
      logic        misalign_q;

      always_ff @(posedge clk) begin
         if (reset) begin
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'h0;
            misalign_q  <= 1'b0;
         end else begin
            rsp_valid_q <= ld_acc;
            misalign_q  <= acc & mis;
            // Data is held between loads; stores do not disturb it.
            if (ld_acc) rsp_rdata_q <= rdata_ext;
         end
      end

      assign rsp_valid = rsp_valid_q;
      assign rsp_rdata = rsp_rdata_q;
      assign misalign  = misalign_q;
   end

endmodule

// File: tb/tb_dmem_bytelane.sv
// tb_dmem_bytelane - drives the same request stream into a combinational-read
// and a registered-read instance (ADDR_W=6, 16 words, clear on reset) and
// checks each against its own queue of expected responses.
module tb_dmem_bytelane;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid, req_we, req_unsigned;
   logic [1:0]  req_size;
   logic [31:0] req_addr, req_wdata;

   logic        rr0, rv0, mi0, bz0;
   logic [31:0] rd0;
   logic        rr1, rv1, mi1, bz1;
   logic [31:0] rd1;

   typedef struct {
      logic        is_load;
      logic        mis;
      logic [31:0] rdata;
   } exp_t;

   exp_t q0[$];
   exp_t q1[$];

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   dmem_bytelane #(.ADDR_W(6), .READ_LATENCY(0), .CLEAR_ON_RESET(1)) u_dut0 (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_we(req_we),
      .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
      .req_wdata(req_wdata), .req_ready(rr0), .rsp_valid(rv0),
      .rsp_rdata(rd0), .misalign(mi0), .busy(bz0)
   );

   dmem_bytelane #(.ADDR_W(6), .READ_LATENCY(1), .CLEAR_ON_RESET(1)) u_dut1 (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_we(req_we),
      .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
      .req_wdata(req_wdata), .req_ready(rr1), .rsp_valid(rv1),
      .rsp_rdata(rd1), .misalign(mi1), .busy(bz1)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
      end
   endtask

   // Responses are compared on the falling edge, away from the active edge.
   task automatic score(input int which, input logic v, input logic m, input logic [31:0] d);
      exp_t e;
      string pfx;
      pfx = (which == 0) ? "lat0" : "lat1";
      if (!(v || m)) return;
      if (((which == 0) ? q0.size() : q1.size()) == 0) begin
         check({pfx, " unexpected_rsp"}, {30'h0, v, m}, 32'h0);
         return;
      end
      e = (which == 0) ? q0.pop_front() : q1.pop_front();
      check({pfx, " rsp_valid"}, {31'h0, v}, {31'h0, e.is_load});
      check({pfx, " misalign"},  {31'h0, m}, {31'h0, e.mis});
      if (e.is_load) check({pfx, " rsp_rdata"}, d, e.rdata);
   endtask

   initial begin
      forever begin
         @(negedge clk);
         score(0, rv0, mi0, rd0);
         score(1, rv1, mi1, rd1);
      end
   end

   task automatic req(input logic we, input logic [1:0] sz, input logic uns,
                      input logic [31:0] addr, input logic [31:0] wd,
                      input logic [31:0] exp_rd, input logic exp_mis);
      exp_t e;
      @(posedge clk); #1;
      req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
      req_addr = addr; req_wdata = wd;
      if (!we || exp_mis) begin
         e.is_load = ~we; e.mis = exp_mis; e.rdata = exp_rd;
         q0.push_back(e);
         q1.push_back(e);
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         req_valid = 1'b0;
      end
   endtask

   // Call right after reset is released (#1 after a rising edge).
   // Busy must hold for exactly 16 cycles; optionally a store is offered in
   // the last busy cycle, which must be ignored.
   task automatic busy_window(input string tag, input logic inject);
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         check({tag, " busy0"},  {31'h0, bz0}, 32'h1);
         check({tag, " busy1"},  {31'h0, bz1}, 32'h1);
         check({tag, " ready0"}, {31'h0, rr0}, 32'h0);
         if (inject && i == 15) begin
            req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_unsigned = 1'b0;
            req_addr = 32'h08; req_wdata = 32'h12345678;
         end
      end
      @(negedge clk);
      req_valid = 1'b0;
      check({tag, " busy0_done"},  {31'h0, bz0}, 32'h0);
      check({tag, " busy1_done"},  {31'h0, bz1}, 32'h0);
      check({tag, " ready1_done"}, {31'h0, rr1}, 32'h1);
   endtask

   initial begin
      reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
      req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check("rst busy0",      {31'h0, bz0}, 32'h1);
      check("rst ready0",     {31'h0, rr0}, 32'h0);
      check("rst rsp_valid1", {31'h0, rv1}, 32'h0);
      check("rst rsp_rdata1", rd1,          32'h0);
      check("rst misalign1",  {31'h0, mi1}, 32'h0);
      reset = 1'b0;

      // 1: clear window, then a cleared word reads zero
      busy_window("clr", 1'b0);
      req(1'b0, 2'b10, 1'b0, 32'h3C, 32'h0, 32'h00000000, 1'b0);

      // 2: lane selection; load immediately after store sees new data
      req(1'b1, 2'b10, 1'b0, 32'h08, 32'h11223344, 32'h0, 1'b0);
      req(1'b0, 2'b00, 1'b0, 32'h09, 32'h0, 32'h00000033, 1'b0);
      req(1'b0, 2'b00, 1'b0, 32'h0B, 32'h0, 32'h00000011, 1'b0);
      req(1'b0, 2'b01, 1'b1, 32'h0A, 32'h0, 32'h00001122, 1'b0);
      req(1'b0, 2'b01, 1'b0, 32'h08, 32'h0, 32'h00003344, 1'b0);
      req(1'b0, 2'b10, 1'b0, 32'h08, 32'h0, 32'h11223344, 1'b0);

      // 3: sign/zero extension and sub-word stores
      req(1'b1, 2'b10, 1'b0, 32'h0C, 32'h00000000, 32'h0, 1'b0);
      req(1'b1, 2'b00, 1'b0, 32'h0D, 32'hFFFFFF80, 32'h0, 1'b0);
      req(1'b0, 2'b00, 1'b0, 32'h0D, 32'h0, 32'hFFFFFF80, 1'b0);
      req(1'b0, 2'b00, 1'b1, 32'h0D, 32'h0, 32'h00000080, 1'b0);
      req(1'b0, 2'b10, 1'b0, 32'h0C, 32'h0, 32'h00008000, 1'b0);
      req(1'b1, 2'b01, 1'b0, 32'h0E, 32'h0000BEEF, 32'h0, 1'b0);
      req(1'b0, 2'b01, 1'b0, 32'h0E, 32'h0, 32'hFFFFBEEF, 1'b0);
      req(1'b0, 2'b01, 1'b1, 32'h0E, 32'h0, 32'h0000BEEF, 1'b0);
      req(1'b0, 2'b10, 1'b1, 32'h0C, 32'h0, 32'hBEEF8000, 1'b0);

      // 4: misaligned / illegal accesses
      req(1'b1, 2'b10, 1'b0, 32'h04, 32'hAAAAAAAA, 32'h0, 1'b0);
      req(1'b1, 2'b10, 1'b0, 32'h06, 32'h00000055, 32'h0, 1'b1);
      req(1'b0, 2'b10, 1'b0, 32'h04, 32'h0, 32'hAAAAAAAA, 1'b0);
      req(1'b0, 2'b01, 1'b0, 32'h03, 32'h0, 32'h00000000, 1'b1);
      req(1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 32'h00000000, 1'b1);

      // 5: address wraps modulo 64 bytes
      req(1'b1, 2'b10, 1'b0, 32'h40, 32'hCAFEF00D, 32'h0, 1'b0);
      req(1'b0, 2'b10, 1'b0, 32'h00, 32'h0, 32'hCAFEF00D, 1'b0);
      req(1'b0, 2'b00, 1'b1, 32'hFFFFFFC3, 32'h0, 32'h000000CA, 1'b0);
      idle(2);

      // 6: reset during clear restarts the sequence; store while busy dropped
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      check("mid_clr busy0", {31'h0, bz0}, 32'h1);
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      busy_window("reclr", 1'b1);
      req(1'b0, 2'b10, 1'b0, 32'h08, 32'h0, 32'h00000000, 1'b0);
      req(1'b0, 2'b10, 1'b0, 32'h00, 32'h0, 32'h00000000, 1'b0);

      // Registered port holds its data and pulses valid for one cycle
      req(1'b1, 2'b10, 1'b0, 32'h10, 32'h0BADF00D, 32'h0, 1'b0);
      req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'h0BADF00D, 1'b0);
      idle(3);
      check("lat1 rdata_hold",  rd1,          32'h0BADF00D);
      check("lat1 valid_pulse", {31'h0, rv1}, 32'h0);
      check("lat0 pending",     q0.size(),    32'h0);
      check("lat1 pending",     q1.size(),    32'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
